// File: rtl/stack_ctrl.sv
// stack_ctrl: hardware stack controller arbitrating interrupt and core push/pop requests onto a single-port stack memory.
//   clk, reset                         : clock, asynchronous active-low reset
//   c_valid/c_op/c_wdata/c_ready       : core request port (op 0=push, 1=pop)
//   c_rsp_valid/c_rsp_rdata/c_rsp_err  : core response port
//   i_*                                : interrupt-unit port, same meaning, wins arbitration
//   mem_req/mem_we/mem_addr/mem_wdata  : stack memory request, held until mem_ack
//   mem_ack/mem_rdata                  : memory completion and read data
//   sp                                 : empty-descending stack pointer
//   overflow/underflow/flag_clr        : sticky error flags and their clear
//   busy                               : controller not idle
module stack_ctrl #(
    parameter logic [15:0] STACK_TOP   = 16'hFFFF,
    parameter logic [15:0] STACK_LIMIT = 16'hFF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c_valid,
    input  logic        c_op,
    input  logic [15:0] c_wdata,
    output logic        c_ready,
    output logic        c_rsp_valid,
    output logic [15:0] c_rsp_rdata,
    output logic        c_rsp_err,
    input  logic        i_valid,
    input  logic        i_op,
    input  logic [15:0] i_wdata,
    output logic        i_ready,
    output logic        i_rsp_valid,
    output logic [15:0] i_rsp_rdata,
    output logic        i_rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] sp,
    output logic        overflow,
    output logic        underflow,
    input  logic        flag_clr,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t      r_state;
    logic        r_owner;
    logic        r_op;
    logic [15:0] r_sp;
    logic        r_ovf;
    logic        r_unf;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [15:0] r_mem_addr;
    logic [15:0] r_mem_wdata;
    logic        r_c_rsp;
    logic        r_i_rsp;
    logic [15:0] r_rdata;
    logic        r_err;
    logic        w_idle;
    logic        w_accept;
    logic        w_op;
    logic [15:0] w_wdata;
    logic        w_bad;
    assign w_idle   = r_state == IDLE;
    assign i_ready  = w_idle && i_valid;
    assign c_ready  = w_idle && c_valid && !i_valid;
    assign w_accept = i_ready || c_ready;
    assign w_op     = i_valid ? i_op : c_op;
    assign w_wdata  = i_valid ? i_wdata : c_wdata;
    // push on a full stack or pop on an empty one is answered without touching memory
    assign w_bad    = w_op ? (r_sp == STACK_TOP) : (r_sp == STACK_LIMIT);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_owner     <= 1'b0;
            r_op        <= 1'b0;
            r_sp        <= STACK_TOP;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_c_rsp     <= 1'b0;
            r_i_rsp     <= 1'b0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            // a flag set later in this block overrides the clear
            if (flag_clr) begin
                r_ovf <= 1'b0;
                r_unf <= 1'b0;
            end
            case (r_state)
                IDLE: if (w_accept) begin
                    r_owner     <= i_valid;
                    r_op        <= w_op;
                    r_mem_wdata <= w_wdata;
                    if (w_bad) begin
                        if (w_op) r_unf <= 1'b1;
                        else      r_ovf <= 1'b1;
                        r_c_rsp <= !i_valid;
                        r_i_rsp <= i_valid;
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_state <= RESP;
                    end else begin
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= !w_op;
                        r_mem_addr <= w_op ? r_sp + 16'd1 : r_sp;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: if (mem_ack) begin
                    r_mem_req <= 1'b0;
                    r_mem_we  <= 1'b0;
                    r_sp      <= r_op ? r_sp + 16'd1 : r_sp - 16'd1;
                    r_rdata   <= r_op ? mem_rdata : 16'd0;
                    r_err     <= 1'b0;
                    r_c_rsp   <= !r_owner;
                    r_i_rsp   <= r_owner;
                    r_state   <= RESP;
                end
                default: begin
                    r_c_rsp <= 1'b0;
                    r_i_rsp <= 1'b0;
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end
    assign c_rsp_valid = r_c_rsp;
    assign c_rsp_rdata = r_c_rsp ? r_rdata : 16'd0;
    assign c_rsp_err   = r_c_rsp && r_err;
    assign i_rsp_valid = r_i_rsp;
    assign i_rsp_rdata = r_i_rsp ? r_rdata : 16'd0;
    assign i_rsp_err   = r_i_rsp && r_err;
    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign sp          = r_sp;
    assign overflow    = r_ovf;
    assign underflow   = r_unf;
    assign busy        = !w_idle;
endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: scoreboard bench for stack_ctrl with a wait-state memory model and a stack reference model.
module tb_stack_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        c_valid = 1'b0, c_op = 1'b0;
    logic [15:0] c_wdata = '0;
    logic        i_valid = 1'b0, i_op = 1'b0;
    logic [15:0] i_wdata = '0;
    logic        c_ready, c_rsp_valid, c_rsp_err;
    logic [15:0] c_rsp_rdata;
    logic        i_ready, i_rsp_valid, i_rsp_err;
    logic [15:0] i_rsp_rdata;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic [15:0] sp;
    logic        overflow, underflow, busy;
    logic        flag_clr = 1'b0;

    always #5 clk = ~clk;

    stack_ctrl dut (
        .clk(clk), .reset(reset),
        .c_valid(c_valid), .c_op(c_op), .c_wdata(c_wdata), .c_ready(c_ready),
        .c_rsp_valid(c_rsp_valid), .c_rsp_rdata(c_rsp_rdata), .c_rsp_err(c_rsp_err),
        .i_valid(i_valid), .i_op(i_op), .i_wdata(i_wdata), .i_ready(i_ready),
        .i_rsp_valid(i_rsp_valid), .i_rsp_rdata(i_rsp_rdata), .i_rsp_err(i_rsp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .sp(sp), .overflow(overflow), .underflow(underflow), .flag_clr(flag_clr), .busy(busy)
    );

    typedef struct packed {
        logic        owner;
        logic [15:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          exp_sp = 32'hFFFF;
    logic [15:0] ref_mem [0:65535];
    logic [15:0] mem [0:65535];
    int          wait_cfg = 0;
    int          wcnt = 0;
    int          req_cyc = 0;
    logic [15:0] last_addr = '0;
    logic        last_we = 1'b0;
    logic        prev_req = 1'b0;
    logic        prev_rsp = 1'b0;
    logic [15:0] prev_addr = '0;
    logic [15:0] prev_wdata = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // memory model plus bus and response monitors, all sampled on the falling edge
    always @(negedge clk) begin
        int pending;
        rsp_t e;
        if (mem_req) begin
            req_cyc++;
            last_addr = mem_addr;
            last_we   = mem_we;
            if (prev_req) begin
                check("mem_addr_stable", 32'(mem_addr), 32'(prev_addr));
                check("mem_wdata_stable", 32'(mem_wdata), 32'(prev_wdata));
            end
            if (wcnt >= wait_cfg) begin
                mem_ack = 1'b1;
                if (mem_we) mem[mem_addr] = mem_wdata;
                mem_rdata = mem_we ? 16'h5A5A : mem[mem_addr];
                wcnt = 0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 16'hA5A5;
                wcnt++;
            end
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = 16'hA5A5;
            wcnt      = 0;
        end
        prev_req   = mem_req;
        prev_addr  = mem_addr;
        prev_wdata = mem_wdata;
        if (c_rsp_valid || i_rsp_valid) begin
            check("rsp_len", 32'(prev_rsp), 32'd0);
            check("rsp_both", 32'(c_rsp_valid & i_rsp_valid), 32'd0);
            pending = exp_q.size();
            check("rsp_pending", 32'(pending != 0), 32'd1);
            if (pending != 0) begin
                e = exp_q.pop_front();
                check("rsp_owner", 32'(i_rsp_valid), 32'(e.owner));
                check("rsp_rdata", 32'(i_rsp_valid ? i_rsp_rdata : c_rsp_rdata), 32'(e.rdata));
                check("rsp_err", 32'(i_rsp_valid ? i_rsp_err : c_rsp_err), 32'(e.err));
            end
        end
        prev_rsp = c_rsp_valid | i_rsp_valid;
    end

    task automatic model(input logic port, input logic op, input logic [15:0] d, output logic err);
        rsp_t e;
        e.owner = port;
        e.rdata = '0;
        e.err   = 1'b0;
        if (!op) begin
            if (exp_sp == 32'hFF00) e.err = 1'b1;
            else begin
                ref_mem[exp_sp] = d;
                exp_sp--;
            end
        end else begin
            if (exp_sp == 32'hFFFF) e.err = 1'b1;
            else begin
                exp_sp++;
                e.rdata = ref_mem[exp_sp];
            end
        end
        exp_q.push_back(e);
        err = e.err;
    endtask

    task automatic drive(input logic port, input logic v, input logic op, input logic [15:0] d);
        if (port) begin
            i_valid = v; i_op = op; i_wdata = d;
        end else begin
            c_valid = v; c_op = op; c_wdata = d;
        end
    endtask

    // raise a request, wait for acceptance, then drop valid one falling edge after the accepting edge
    task automatic req(input logic port, input logic op, input logic [15:0] d);
        logic err;
        int n;
        n = 0;
        drive(port, 1'b1, op, d);
        #1;
        while (!(port ? i_ready : c_ready)) begin
            if (n++ > 200) begin
                check("ready_timeout", 32'(port ? i_ready : c_ready), 32'd1);
                drive(port, 1'b0, 1'b0, 16'd0);
                return;
            end
            tick();
            #1;
        end
        model(port, op, d, err);
        req_cyc = 0;
        @(posedge clk);
        tick();
        drive(port, 1'b0, 1'b0, 16'd0);
        check("lat_mem_req", 32'(mem_req), 32'(!err));
        check("lat_err_rsp", 32'(port ? i_rsp_valid : c_rsp_valid), 32'(err));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy) begin
            tick();
            if (n++ > 100) begin
                check("idle_timeout", 32'(busy), 32'd0);
                return;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) tick();
        check("rst_sp", 32'(sp), 32'hFFFF);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_flags", 32'({overflow, underflow}), 32'd0);
        check("rst_rsp", 32'({c_rsp_valid, i_rsp_valid}), 32'd0);
        reset = 1'b1;
        tick();
        // core push with two memory wait states
        wait_cfg = 2;
        req(1'b0, 1'b0, 16'hBEEF);
        wait_idle();
        check("push_addr", 32'(last_addr), 32'hFFFF);
        check("push_we", 32'(last_we), 32'd1);
        check("push_req_cycles", 32'(req_cyc), 32'd3);
        check("push_sp", 32'(sp), 32'hFFFE);
        check("push_mem", 32'(mem[16'hFFFF]), 32'hBEEF);
        // core pop returns the pushed word
        wait_cfg = 0;
        req(1'b0, 1'b1, 16'd0);
        wait_idle();
        check("pop_addr", 32'(last_addr), 32'hFFFF);
        check("pop_we", 32'(last_we), 32'd0);
        check("pop_sp", 32'(sp), 32'hFFFF);
        // pop on empty stack
        req(1'b0, 1'b1, 16'd0);
        wait_idle();
        check("unf_no_mem", 32'(req_cyc), 32'd0);
        check("unf_flag", 32'(underflow), 32'd1);
        check("unf_sp", 32'(sp), 32'hFFFF);
        repeat (3) tick();
        check("unf_sticky", 32'(underflow), 32'd1);
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        check("unf_clr", 32'(underflow), 32'd0);
        // set and clear on the same edge: set wins
        flag_clr = 1'b1;
        req(1'b1, 1'b1, 16'd0);
        flag_clr = 1'b0;
        check("unf_set_wins", 32'(underflow), 32'd1);
        wait_idle();
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        check("unf_clr2", 32'(underflow), 32'd0);
        // simultaneous pushes: interrupt first, core next
        drive(1'b0, 1'b1, 1'b0, 16'h1111);
        drive(1'b1, 1'b1, 1'b0, 16'h2222);
        #1;
        check("arb_i_ready", 32'(i_ready), 32'd1);
        check("arb_c_ready", 32'(c_ready), 32'd0);
        begin
            logic err;
            model(1'b1, 1'b0, 16'h2222, err);
        end
        @(posedge clk);
        tick();
        drive(1'b1, 1'b0, 1'b0, 16'd0);
        check("arb_c_wait", 32'(c_ready), 32'd0);
        check("arb_i_issue", 32'(mem_req), 32'd1);
        wait_idle();
        req(1'b0, 1'b0, 16'h1111);
        wait_idle();
        check("arb_sp", 32'(sp), 32'hFFFD);
        // simultaneous pops: interrupt takes the top word
        drive(1'b0, 1'b1, 1'b1, 16'd0);
        req(1'b1, 1'b1, 16'd0);
        wait_idle();
        req(1'b0, 1'b1, 16'd0);
        wait_idle();
        check("arb_pop_sp", 32'(sp), 32'hFFFF);
        // fill the stack with zero-wait memory
        for (int k = 0; k < 255; k++) begin
            req(k[0], 1'b0, 16'($urandom));
            wait_idle();
        end
        check("full_sp", 32'(sp), 32'hFF00);
        check("full_no_ovf", 32'(overflow), 32'd0);
        req(1'b0, 1'b0, 16'hDEAD);
        wait_idle();
        check("ovf_no_mem", 32'(req_cyc), 32'd0);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_sp", 32'(sp), 32'hFF00);
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);
        req(1'b1, 1'b0, 16'hCAFE);
        wait_idle();
        check("ovf_again", 32'(overflow), 32'd1);
        for (int k = 0; k < 3; k++) begin
            req(1'b0, 1'b1, 16'd0);
            wait_idle();
        end
        check("lifo_sp", 32'(sp), 32'hFF03);
        // reset while the memory access is outstanding
        reset = 1'b0;
        tick();
        reset = 1'b1;
        exp_sp = 32'hFFFF;
        tick();
        check("rst2_ovf", 32'(overflow), 32'd0);
        wait_cfg = 20;
        req(1'b0, 1'b0, 16'hAAAA);
        repeat (2) tick();
        check("abort_req_before", 32'(mem_req), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("abort_req_drop", 32'(mem_req), 32'd0);
        check("abort_sp", 32'(sp), 32'hFFFF);
        check("abort_busy", 32'(busy), 32'd0);
        exp_q.delete();
        exp_sp = 32'hFFFF;
        repeat (3) tick();
        check("abort_no_rsp", 32'({c_rsp_valid, i_rsp_valid}), 32'd0);
        // first acceptance on the first edge after release
        wait_cfg = 0;
        reset = 1'b1;
        req(1'b0, 1'b0, 16'h4321);
        wait_idle();
        check("post_rst_sp", 32'(sp), 32'hFFFE);
        req(1'b0, 1'b1, 16'd0);
        wait_idle();
        repeat (3) tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
